// File: rtl/atm_pkg.sv
// Shared definitions for the ATM controller: FSM state encodings and
// transaction type codes used by the top level and the testbench.
package atm_pkg;

  typedef enum logic [1:0] {
    ESPERA        = 2'd0,
    VERIFICAR_PIN = 2'd1,
    ESPERA_MONTO  = 2'd2,
    BLOQUEO       = 2'd3
  } state_t;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/atm_pin_collector.sv
// PIN collector: shifts keypad digits into a register, counts them, and
// flags the strobe that completes the PIN together with the match result.
// pin_done/pin_ok are combinational and valid only during the completing
// strobe, so the controller can react on that same clock edge.
module atm_pin_collector
  import atm_pkg::*;
#(
  parameter int                      PIN_DIGITS  = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN_CORRECT = 16'h4756
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] digito,
  input  logic       digito_stb,
  output logic       pin_done,
  output logic       pin_ok
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int SR_W  = 4 * PIN_DIGITS;

  logic [SR_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W+3:0]  shift_ext;
  logic [SR_W-1:0]  candidate;
  logic             accept;

  // The candidate PIN includes the digit arriving right now, so the final
  // digit can be compared without waiting another cycle.
  assign shift_ext = {shift_q, digito};
  assign candidate = shift_ext[SR_W-1:0];
  assign accept    = enable && digito_stb;
  assign pin_done  = accept && (cnt_q == CNT_W'(PIN_DIGITS - 1));
  assign pin_ok    = pin_done && (candidate == PIN_CORRECT);

  // Next-state for the shift register and digit counter; the counter wraps
  // to zero when a PIN is completed so a retry starts clean.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d = candidate;
      cnt_d   = pin_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Register the collector state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/atm_controller_param.sv
// Parametrised ATM transaction controller: card session FSM, attempt
// limiting with warning and sticky lockout, and a saturating balance
// datapath for one deposit or withdrawal per session.
module atm_controller_param
  import atm_pkg::*;
#(
  parameter int                      PIN_DIGITS   = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN_CORRECT  = 16'h4756,
  parameter int                      MAX_ATTEMPTS = 3,
  parameter int                      MONTO_W      = 32,
  parameter int                      BAL_W        = 64,
  parameter logic [BAL_W-1:0]        BAL_INIT     = BAL_W'(20000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tarjeta_recibida,
  input  logic               tipo_trans,
  input  logic [3:0]         digito,
  input  logic               digito_stb,
  input  logic [MONTO_W-1:0] monto,
  input  logic               monto_stb,
  output logic               balance_actualizado,
  output logic               entregar_dinero,
  output logic               pin_incorrecto,
  output logic               advertencia,
  output logic               bloqueo,
  output logic               fondos_insuficientes,
  output logic [BAL_W-1:0]   balance
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

  state_t           state_q;
  logic [ATT_W-1:0] attempts_q;
  logic [ATT_W-1:0] attempts_d;
  logic [BAL_W-1:0] balance_q;
  logic             bal_act_q, entregar_q, pin_inc_q, adv_q, bloqueo_q, fondos_q;

  logic             pin_done, pin_ok;
  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   deposit_sum;
  logic [BAL_W-1:0] deposit_d;
  logic             retiro_ok;

  atm_pin_collector #(
    .PIN_DIGITS  (PIN_DIGITS),
    .PIN_CORRECT (PIN_CORRECT)
  ) u_pin (
    .clk        (clk),
    .rst        (rst),
    .enable     (state_q == VERIFICAR_PIN),
    .clear      ((state_q == ESPERA) && tarjeta_recibida),
    .digito     (digito),
    .digito_stb (digito_stb),
    .pin_done   (pin_done),
    .pin_ok     (pin_ok)
  );

  // Deposits saturate at the all-ones balance instead of wrapping; the
  // extra carry bit of the widened sum detects overflow.
  assign monto_ext   = BAL_W'(monto);
  assign deposit_sum = {1'b0, balance_q} + {1'b0, monto_ext};
  assign deposit_d   = deposit_sum[BAL_W] ? '1 : deposit_sum[BAL_W-1:0];
  assign retiro_ok   = (monto_ext <= balance_q);
  assign attempts_d  = attempts_q + ATT_W'(1);

  // Session FSM with registered outputs; pulse outputs default low each
  // cycle so they last exactly one cycle after the triggering strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ESPERA;
      attempts_q <= '0;
      balance_q  <= BAL_INIT;
      bal_act_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      adv_q      <= 1'b0;
      bloqueo_q  <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      bal_act_q  <= 1'b0;
      entregar_q <= 1'b0;
      pin_inc_q  <= 1'b0;
      fondos_q   <= 1'b0;
      case (state_q)
        ESPERA: begin
          if (tarjeta_recibida) begin
            state_q    <= VERIFICAR_PIN;
            attempts_q <= '0;
          end
        end
        VERIFICAR_PIN: begin
          if (pin_done) begin
            if (pin_ok) begin
              state_q    <= ESPERA_MONTO;
              adv_q      <= 1'b0;
              attempts_q <= '0;
            end else begin
              pin_inc_q  <= 1'b1;
              attempts_q <= attempts_d;
              if (attempts_d == ATT_W'(MAX_ATTEMPTS)) begin
                state_q   <= BLOQUEO;
                bloqueo_q <= 1'b1;
                adv_q     <= 1'b0;
              end else if (attempts_d == ATT_W'(MAX_ATTEMPTS - 1)) begin
                adv_q <= 1'b1;
              end
            end
          end
        end
        ESPERA_MONTO: begin
          if (monto_stb) begin
            state_q <= ESPERA;
            if (tipo_trans == TIPO_DEPOSITO) begin
              balance_q <= deposit_d;
              bal_act_q <= 1'b1;
            end else if (retiro_ok) begin
              balance_q  <= balance_q - monto_ext;
              bal_act_q  <= 1'b1;
              entregar_q <= 1'b1;
            end else begin
              fondos_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= BLOQUEO;
        end
      endcase
    end
  end

  assign balance_actualizado  = bal_act_q;
  assign entregar_dinero      = entregar_q;
  assign pin_incorrecto       = pin_inc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = bloqueo_q;
  assign fondos_insuficientes = fondos_q;
  assign balance              = balance_q;

endmodule

// File: tb/tb_atm_controller_param.sv
// Directed testbench for atm_controller_param. A second instance with a
// 16-bit balance shares all inputs and is used for the saturation case.
module tb_atm_controller_param;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_trans = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic        digito_stb = 1'b0;
  logic [31:0] monto = 32'd0;
  logic        monto_stb = 1'b0;

  logic        balAct, entregar, pinInc, adv, bloq, fondos;
  logic [63:0] balance;
  logic        satBalAct, satEntregar, satPinInc, satAdv, satBloq, satFondos;
  logic [15:0] satBalance;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  atm_controller_param dut (
    .clk                  (clk),
    .rst                  (rst),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito               (digito),
    .digito_stb           (digito_stb),
    .monto                (monto),
    .monto_stb            (monto_stb),
    .balance_actualizado  (balAct),
    .entregar_dinero      (entregar),
    .pin_incorrecto       (pinInc),
    .advertencia          (adv),
    .bloqueo              (bloq),
    .fondos_insuficientes (fondos),
    .balance              (balance)
  );

  atm_controller_param #(
    .MONTO_W  (16),
    .BAL_W    (16),
    .BAL_INIT (16'd65000)
  ) dutSat (
    .clk                  (clk),
    .rst                  (rst),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito               (digito),
    .digito_stb           (digito_stb),
    .monto                (monto[15:0]),
    .monto_stb            (monto_stb),
    .balance_actualizado  (satBalAct),
    .entregar_dinero      (satEntregar),
    .pin_incorrecto       (satPinInc),
    .advertencia          (satAdv),
    .bloqueo              (satBloq),
    .fondos_insuficientes (satFondos),
    .balance              (satBalance)
  );

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs starting at a falling edge; returns at the next
  // falling edge, where the registered response to that cycle is visible.
  task automatic applyStimulus(input logic card, input logic dStb, input logic [3:0] dig,
                               input logic mStb, input logic tipo, input logic [31:0] amt);
    tarjeta_recibida = card;
    digito_stb       = dStb;
    digito           = dig;
    monto_stb        = mStb;
    tipo_trans       = tipo;
    monto            = amt;
    @(negedge clk);
    tarjeta_recibida = 1'b0;
    digito_stb       = 1'b0;
    monto_stb        = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic card();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic digit(input logic [3:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic enterPin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    digit(a);
    digit(b);
    digit(c);
    digit(d);
  endtask

  task automatic transaction(input logic tipo, input logic [31:0] amt);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, tipo, amt);
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state
    checkOutput("rst_balance", balance, 64'd20000);
    checkOutput("rst_state", dut.state_q, ESPERA);
    checkOutput("rst_pulses", {balAct, entregar, pinInc, adv, bloq, fondos}, 0);

    // Amount strobe in ESPERA is ignored
    transaction(TIPO_DEPOSITO, 32'd500);
    checkOutput("idle_monto_balance", balance, 64'd20000);
    checkOutput("idle_monto_pulse", balAct, 1'b0);

    // Deposit 10000 with correct PIN
    card();
    checkOutput("t1_state_verif", dut.state_q, VERIFICAR_PIN);
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    checkOutput("t1_state_monto", dut.state_q, ESPERA_MONTO);
    checkOutput("t1_no_pininc", pinInc, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, TIPO_DEPOSITO, 32'd10000);
    checkOutput("t1_balance", balance, 64'd30000);
    checkOutput("t1_balact", balAct, 1'b1);
    checkOutput("t1_entregar", entregar, 1'b0);
    checkOutput("t1_state_espera", dut.state_q, ESPERA);
    idle();
    checkOutput("t1_balact_drop", balAct, 1'b0);

    // Withdrawal 15000
    doReset();
    card();
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    transaction(TIPO_RETIRO, 32'd15000);
    checkOutput("t2_balance", balance, 64'd5000);
    checkOutput("t2_pulses", {balAct, entregar, fondos}, 3'b110);
    idle();
    checkOutput("t2_pulses_drop", {balAct, entregar}, 2'b00);

    // Insufficient funds, then exact-balance withdrawal
    doReset();
    card();
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    transaction(TIPO_RETIRO, 32'd25000);
    checkOutput("t3_fondos", fondos, 1'b1);
    checkOutput("t3_balance", balance, 64'd20000);
    checkOutput("t3_no_dispense", {balAct, entregar}, 2'b00);
    checkOutput("t3_state", dut.state_q, ESPERA);
    idle();
    checkOutput("t3_fondos_drop", fondos, 1'b0);
    card();
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    transaction(TIPO_RETIRO, 32'd20000);
    checkOutput("t3_exact_balance", balance, 64'd0);
    checkOutput("t3_exact_pulses", {balAct, entregar, fondos}, 3'b110);

    // Three wrong PINs lead to sticky lockout
    doReset();
    card();
    enterPin(4'd1, 4'd2, 4'd3, 4'd4);
    checkOutput("t4_w1_pininc", pinInc, 1'b1);
    checkOutput("t4_w1_adv", adv, 1'b0);
    idle();
    checkOutput("t4_pininc_drop", pinInc, 1'b0);
    enterPin(4'd1, 4'd2, 4'd3, 4'd4);
    checkOutput("t4_w2_pininc", pinInc, 1'b1);
    checkOutput("t4_w2_adv", adv, 1'b1);
    checkOutput("t4_w2_bloq", bloq, 1'b0);
    enterPin(4'd1, 4'd2, 4'd3, 4'd4);
    checkOutput("t4_w3_pininc", pinInc, 1'b1);
    checkOutput("t4_w3_bloq_adv", {bloq, adv}, 2'b10);
    checkOutput("t4_w3_state", dut.state_q, BLOQUEO);
    card();
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    transaction(TIPO_DEPOSITO, 32'd100);
    checkOutput("t4_locked_bloq", bloq, 1'b1);
    checkOutput("t4_locked_state", dut.state_q, BLOQUEO);
    checkOutput("t4_locked_balance", balance, 64'd20000);
    doReset();
    checkOutput("t4_reset_clears", bloq, 1'b0);

    // Two wrong then correct; a new card gets a fresh attempt budget
    card();
    enterPin(4'd9, 4'd9, 4'd9, 4'd9);
    enterPin(4'd4, 4'd7, 4'd5, 4'd7);
    checkOutput("t5_adv_set", adv, 1'b1);
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    checkOutput("t5_adv_clear", adv, 1'b0);
    checkOutput("t5_state", dut.state_q, ESPERA_MONTO);
    transaction(TIPO_DEPOSITO, 32'd0);
    checkOutput("t5_zero_balact", balAct, 1'b1);
    checkOutput("t5_zero_balance", balance, 64'd20000);
    card();
    enterPin(4'd1, 4'd2, 4'd3, 4'd4);
    checkOutput("t5_new_w1", {pinInc, adv, bloq}, 3'b100);
    enterPin(4'd15, 4'd7, 4'd5, 4'd6);
    checkOutput("t5_new_w2", {pinInc, adv, bloq}, 3'b110);
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    checkOutput("t5_new_ok_state", dut.state_q, ESPERA_MONTO);

    // Reset mid-PIN aborts the session; stray digits are ignored afterwards
    doReset();
    card();
    digit(4'd4);
    digit(4'd7);
    doReset();
    checkOutput("t6_outputs", {balAct, entregar, pinInc, adv, bloq, fondos}, 0);
    checkOutput("t6_balance", balance, 64'd20000);
    checkOutput("t6_state", dut.state_q, ESPERA);
    enterPin(4'd1, 4'd2, 4'd3, 4'd4);
    checkOutput("t6_stray_pininc", pinInc, 1'b0);
    checkOutput("t6_stray_state", dut.state_q, ESPERA);
    card();
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    checkOutput("t6_newcard_state", dut.state_q, ESPERA_MONTO);

    // Saturating deposit on the 16-bit instance
    doReset();
    checkOutput("sat_rst_balance", satBalance, 16'd65000);
    card();
    enterPin(4'd4, 4'd7, 4'd5, 4'd6);
    transaction(TIPO_DEPOSITO, 32'd1000);
    checkOutput("sat_balance", satBalance, 16'd65535);
    checkOutput("sat_balact", satBalAct, 1'b1);
    checkOutput("sat_main_balance", balance, 64'd21000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
